piso_serializer_tx: RTL
=======================

Name: piso_serializer_tx

Overview:
- Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on serial_out, with frame_out marking valid bit slots.
- It is the transmit-side counterpart to a serial-in shift receiver built from the team's D flip-flop cells.
- Its serial_out and frame_out pins drive that receiver's data and enable inputs directly, on the same clock.

Parameters:
- WIDTH, 8, data word width in bits; legal range is 2 or more.
- MSB_FIRST, 1, set to 1 to shift bit WIDTH-1 first; set to 0 to shift bit 0 first.

Ports:
- clk_signal  input  1  system clock; all state updates on its rising edge.
- rst_signal  input  1  reset, synchronous, active-high.
- D_in  input  WIDTH  parallel word to transmit; sampled only on handshake.
- load_valid  input  1  D_in holds a word to send.
- load_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  serial data bit; registered.
- frame_out  output  1  high while serial_out carries a data or parity bit; registered.
- done_pulse  output  1  one-cycle strobe after the last bit of a frame.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk_signal. Reset has priority over every other event.
- Reset values:
  - state = IDLE, shift_reg = 0, bit_cnt = 0.
  - serial_out = 0, frame_out = 0, done_pulse = 0, busy = 0, load_ready = 1.
- States: IDLE, SHIFT, PARITY (exists only with the optional feature), DONE.
- load_ready is 1 only in IDLE. busy = not IDLE. All outputs are registered or are pure state decodes; there are no combinational paths from inputs to outputs.
- Handshake: a word is accepted on edge E0 when state is IDLE, load_valid = 1 and rst_signal = 0. On E0:
  - shift_reg <= D_in and bit_cnt <= 1;
  - serial_out <= first bit (D_in[WIDTH-1] if MSB_FIRST, else D_in[0]);
  - frame_out <= 1 and state <= SHIFT.
- Latency: the first bit is visible in the cycle after E0.
- SHIFT: each edge presents the next bit and increments bit_cnt.
  - Bit k of the transmission order is on serial_out during cycle k (k = 0 .. WIDTH-1, counted from E0).
  - frame_out stays 1 for exactly WIDTH cycles.
  - On the edge where bit_cnt == WIDTH: go to DONE (or to PARITY with the feature). In DONE, serial_out <= 0, frame_out <= 0, done_pulse <= 1.
- DONE: lasts one cycle, then state <= IDLE, done_pulse <= 0, load_ready = 1.
- Minimum spacing between acceptance edges is WIDTH+2 cycles (WIDTH+3 with parity).
- Changes on load_valid or D_in outside IDLE are ignored. The captured word is immune to later changes on D_in.
- load_valid held high continuously: the next word is accepted on the first edge in IDLE. No word is dropped or duplicated.
- Reset mid-frame (SHIFT, PARITY or DONE): on the next edge all registers take their reset values. The frame is truncated, no done_pulse is generated, and load_ready = 1 in the following cycle.
- bit_cnt width is clog2(WIDTH+2) and it never wraps within a frame.
- Outside a frame, serial_out is 0.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- When defined: after the last data bit the FSM enters PARITY for one cycle, with frame_out = 1 and serial_out = XOR of all WIDTH bits of the captured word (even parity). It then enters DONE. frame_out is high for WIDTH+1 cycles.
- When undefined: the PARITY state and its logic are absent, SHIFT transitions directly to DONE, and the frame is WIDTH cycles.

Test Plan:
- Reset: hold rst_signal = 1 for 2 edges with load_valid = 1 -> serial_out = 0, frame_out = 0, done_pulse = 0, busy = 0, load_ready = 1, and no word is accepted.
- WIDTH = 8, MSB_FIRST = 1, load 0xA5 -> serial_out = 1,0,1,0,0,1,0,1 in cycles 0-7 after acceptance; frame_out high for exactly those 8 cycles; done_pulse = 1 in cycle 8; load_ready = 1 in cycle 9.
- MSB_FIRST = 0, load 0x01 -> serial_out = 1 then 0 for seven cycles; done_pulse exactly once.
- Back-to-back: load_valid held at 1 with D_in = 0x3C, switching to 0xFF in cycle 2 -> frame 1 carries 0x3C unaltered; 0xFF is accepted on the first IDLE edge; the gap is 2 cycles with frame_out = 0.
- Abort: load 0xF0, assert rst_signal in cycle 4 of the frame -> frame_out = 0 from the next cycle, no done_pulse, load_ready = 1, and a following load of 0x0F transmits correctly.
- With PISO_TX_PARITY_EN: load 0x07 -> 8 data bits, then a 9th bit = 1 with frame_out high; load 0x03 -> 9th bit = 0; done_pulse in cycle 9.

Source files
------------

// File: rtl/piso_serializer_tx.sv
// rtl/piso_serializer_tx.sv - parallel-in/serial-out transmitter with valid/ready word load
// Optional even-parity bit after the data bits is enabled by defining PISO_TX_PARITY_EN.
module piso_serializer_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk_signal,
  input  logic             rst_signal,
  input  logic [WIDTH-1:0] D_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             frame_out,
  output logic             done_pulse,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
`ifdef PISO_TX_PARITY_EN
    , PARITY = 2'd3
`endif
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift_reg;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_serial;
  logic             r_frame;
  logic             r_done;
`ifdef PISO_TX_PARITY_EN
  logic             r_parity;
`endif

  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shifted;

  // The register shifts toward the transmit end so the next bit is always at a fixed index.
  always_comb begin
    w_first_bit = (MSB_FIRST != 0) ? D_in[WIDTH-1] : D_in[0];
    w_next_bit  = (MSB_FIRST != 0) ? r_shift_reg[WIDTH-2] : r_shift_reg[1];
    w_shifted   = (MSB_FIRST != 0) ? {r_shift_reg[WIDTH-2:0], 1'b0}
                                   : {1'b0, r_shift_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk_signal) begin
    if (rst_signal) begin
      r_state     <= IDLE;
      r_shift_reg <= '0;
      r_bit_cnt   <= '0;
      r_serial    <= 1'b0;
      r_frame     <= 1'b0;
      r_done      <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (load_valid) begin
            r_shift_reg <= D_in;
            r_bit_cnt   <= CW'(1);
            r_serial    <= w_first_bit;
            r_frame     <= 1'b1;
            r_state     <= SHIFT;
`ifdef PISO_TX_PARITY_EN
            r_parity    <= ^D_in;
`endif
          end
        end
        SHIFT: begin
          if (r_bit_cnt == LAST_CNT) begin
`ifdef PISO_TX_PARITY_EN
            r_serial <= r_parity;
            r_state  <= PARITY;
`else
            r_serial <= 1'b0;
            r_frame  <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
`endif
          end else begin
            r_shift_reg <= w_shifted;
            r_serial    <= w_next_bit;
            r_bit_cnt   <= r_bit_cnt + CW'(1);
          end
        end
`ifdef PISO_TX_PARITY_EN
        PARITY: begin
          r_serial <= 1'b0;
          r_frame  <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= DONE;
        end
`endif
        DONE: begin
          r_done    <= 1'b0;
          r_bit_cnt <= '0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign load_ready = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign serial_out = r_serial;
  assign frame_out  = r_frame;
  assign done_pulse = r_done;

endmodule
